// File: rtl/switch_input_port_pkg.sv
`default_nettype none
// ============================================================================
// switch_input_port_pkg : shared chiplet switch types (flit fields, VC state,
//                         credit) and small elaboration helpers
// Revision: 1.0
// ============================================================================
package switch_input_port_pkg;

   localparam int FLIT_ID_LSB  = 0;
   localparam int FLIT_ID_W    = 8;

   // Stored FIFO entry is {tail, head, payload}; offsets are above the payload.
   localparam int ENT_HEAD_OFS = 0;
   localparam int ENT_TAIL_OFS = 1;
   localparam int ENT_EXTRA_W  = 2;

   typedef enum logic [1:0] {
      VC_IDLE    = 2'd0,
      VC_ROUTING = 2'd1,
      VC_ACTIVE  = 2'd2
   } vc_state_e;

   localparam int CREDIT_VC_W = 8;

   typedef struct packed {
      logic                   valid;
      logic [CREDIT_VC_W-1:0] vc;
   } credit_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rr_index(input int base, input int off, input int n);
      return (base + off >= n) ? (base + off - n) : (base + off);
   endfunction

endpackage
`default_nettype wire

// File: rtl/switch_input_port_if.sv
`default_nettype none
// ============================================================================
// switch_input_port_if : link, route-compute and switch-allocation signals of
//                        one switch input port
// Revision: 1.0
// ============================================================================
interface switch_input_port_if
   import switch_input_port_pkg::*;
#(
   parameter int FLIT_W       = 64,
   parameter int NUM_VCS      = 2,
   parameter int NUM_OUTPORTS = 5
);
   localparam int VC_W  = clog2_min1(NUM_VCS);
   localparam int OUT_W = clog2_min1(NUM_OUTPORTS);

   logic              in_valid;
   logic [VC_W-1:0]   in_vc;
   logic              in_head;
   logic              in_tail;
   logic [FLIT_W-1:0] in_flit;
   logic              credit_valid;
   logic [VC_W-1:0]   credit_vc;
   logic              rc_req;
   logic [FLIT_W-1:0] rc_flit;
   logic [VC_W-1:0]   rc_vc;
   logic              rc_done;
   logic [OUT_W-1:0]  rc_outport;
   logic              sa_req;
   logic [OUT_W-1:0]  sa_outport;
   logic              sa_grant;
   logic              out_valid;
   logic [FLIT_W-1:0] out_flit;
   logic [NUM_VCS-1:0] vc_full;

   modport master (
      output in_valid, in_vc, in_head, in_tail, in_flit, rc_done, rc_outport, sa_grant,
      input  credit_valid, credit_vc, rc_req, rc_flit, rc_vc, sa_req, sa_outport,
             out_valid, out_flit, vc_full
   );

   modport slave (
      input  in_valid, in_vc, in_head, in_tail, in_flit, rc_done, rc_outport, sa_grant,
      output credit_valid, credit_vc, rc_req, rc_flit, rc_vc, sa_req, sa_outport,
             out_valid, out_flit, vc_full
   );

endinterface
`default_nettype wire

// File: rtl/switch_input_port_vc_fifo.sv
`default_nettype none
// ============================================================================
// switch_input_port_vc_fifo : one virtual-channel flit FIFO, combinational
//                             front read, wrap-bit full/empty detection
// Revision: 1.0
// ============================================================================
module switch_input_port_vc_fifo
   import switch_input_port_pkg::*;
#(
   parameter int DATA_W = 66,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_full,
   output logic              o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + PW'(1);
         if (i_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/switch_input_port.sv
`default_nettype none
// ============================================================================
// switch_input_port : per-link input unit - VC FIFOs, route-compute request,
//                     round-robin switch allocation request, credit return.
// Option: SWITCH_INPUT_PORT_ERR_CNT_EN adds a saturating err_count output.
// Revision: 1.0
// ============================================================================
module switch_input_port
   import switch_input_port_pkg::*;
#(
   parameter int FLIT_W       = 64,
   parameter int NUM_VCS      = 2,
   parameter int BUFFER_DEPTH = 4,
   parameter int NUM_OUTPORTS = 5
) (
   input  logic               clk,
   input  logic               n_rst,
   switch_input_port_if.slave bus
`ifdef SWITCH_INPUT_PORT_ERR_CNT_EN
   ,
   output logic [15:0]        err_count
`endif
);
   localparam int VC_W  = clog2_min1(NUM_VCS);
   localparam int OUT_W = clog2_min1(NUM_OUTPORTS);
   localparam int ENT_W = FLIT_W + ENT_EXTRA_W;

   logic [NUM_VCS-1:0] w_push, w_pop, w_full, w_empty;
   logic [NUM_VCS-1:0] w_front_head, w_front_tail, w_elig, w_route_ld;
   logic [ENT_W-1:0]   w_rdata [NUM_VCS];
   vc_state_e          r_state [NUM_VCS];
   vc_state_e          w_state_nxt [NUM_VCS];
   logic [OUT_W-1:0]   r_route [NUM_VCS];
   logic [VC_W-1:0]    r_rr, w_rr_nxt, w_sel, w_rc_vc, w_drop_vc;
   logic               w_sa_req, w_grant_fire, w_rc_req, w_drop;
   logic               r_credit_valid;
   logic [VC_W-1:0]    r_credit_vc;

   for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      switch_input_port_vc_fifo #(
         .DATA_W (ENT_W),
         .DEPTH  (BUFFER_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .n_rst   (n_rst),
         .i_push  (w_push[v]),
         .i_pop   (w_pop[v]),
         .i_wdata ({bus.in_tail, bus.in_head, bus.in_flit}),
         .o_rdata (w_rdata[v]),
         .o_full  (w_full[v]),
         .o_empty (w_empty[v])
      );

      // A full VC still accepts a write when it is being popped the same cycle.
      assign w_push[v]       = bus.in_valid && (bus.in_vc == VC_W'(v)) && (!w_full[v] || w_pop[v]);
      assign w_front_head[v] = w_rdata[v][FLIT_W + ENT_HEAD_OFS];
      assign w_front_tail[v] = w_rdata[v][FLIT_W + ENT_TAIL_OFS];
      assign w_elig[v]       = (r_state[v] == VC_ACTIVE) && !w_empty[v];
   end

   always_comb begin
      w_sa_req = 1'b0;
      w_sel    = '0;
      for (int i = 0; i < NUM_VCS; i++) begin
         if (!w_sa_req && w_elig[rr_index(int'(r_rr), i, NUM_VCS)]) begin
            w_sa_req = 1'b1;
            w_sel    = VC_W'(rr_index(int'(r_rr), i, NUM_VCS));
         end
      end
   end

   assign w_grant_fire = w_sa_req && bus.sa_grant;
   assign w_rr_nxt     = (w_sel == VC_W'(NUM_VCS - 1)) ? '0 : w_sel + VC_W'(1);

   // Malformed-flit discards yield to a granted pop so only one credit leaves per cycle.
   always_comb begin
      w_rc_req  = 1'b0;
      w_rc_vc   = '0;
      w_drop    = 1'b0;
      w_drop_vc = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         if (!w_rc_req && (r_state[v] == VC_ROUTING)) begin
            w_rc_req = 1'b1;
            w_rc_vc  = VC_W'(v);
         end
         if (!w_drop && !w_grant_fire && (r_state[v] == VC_IDLE) && !w_empty[v] && !w_front_head[v]) begin
            w_drop    = 1'b1;
            w_drop_vc = VC_W'(v);
         end
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         w_pop[v]       = (w_grant_fire && (w_sel == VC_W'(v))) || (w_drop && (w_drop_vc == VC_W'(v)));
         w_state_nxt[v] = r_state[v];
         w_route_ld[v]  = 1'b0;
         case (r_state[v])
            VC_IDLE: begin
               if (!w_empty[v] && w_front_head[v]) w_state_nxt[v] = VC_ROUTING;
            end
            VC_ROUTING: begin
               if (bus.rc_done && w_rc_req && (w_rc_vc == VC_W'(v))) begin
                  w_state_nxt[v] = VC_ACTIVE;
                  w_route_ld[v]  = 1'b1;
               end
            end
            VC_ACTIVE: begin
               if (w_pop[v] && w_front_tail[v]) w_state_nxt[v] = VC_IDLE;
            end
            default: w_state_nxt[v] = VC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            r_state[v] <= VC_IDLE;
            r_route[v] <= '0;
         end
         r_rr           <= '0;
         r_credit_valid <= 1'b0;
         r_credit_vc    <= '0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            r_state[v] <= w_state_nxt[v];
            if (w_route_ld[v]) r_route[v] <= bus.rc_outport;
         end
         if (w_grant_fire) r_rr <= w_rr_nxt;
         r_credit_valid <= w_grant_fire || w_drop;
         r_credit_vc    <= w_grant_fire ? w_sel : (w_drop ? w_drop_vc : '0);
      end
   end

   assign bus.rc_req       = w_rc_req;
   assign bus.rc_vc        = w_rc_vc;
   assign bus.rc_flit      = w_rc_req ? w_rdata[w_rc_vc][FLIT_W-1:0] : '0;
   assign bus.sa_req       = w_sa_req;
   assign bus.sa_outport   = w_sa_req ? r_route[w_sel] : '0;
   assign bus.out_valid    = w_grant_fire;
   assign bus.out_flit     = w_grant_fire ? w_rdata[w_sel][FLIT_W-1:0] : '0;
   assign bus.credit_valid = r_credit_valid;
   assign bus.credit_vc    = r_credit_vc;
   assign bus.vc_full      = w_full;

`ifdef SWITCH_INPUT_PORT_ERR_CNT_EN
   logic        w_wr_err;
   logic [16:0] w_err_sum;
   logic [15:0] r_err_count;

   assign w_wr_err  = bus.in_valid && w_full[bus.in_vc] && !w_pop[bus.in_vc];
   assign w_err_sum = {1'b0, r_err_count} + 17'(w_wr_err) + 17'(w_drop);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_err_count <= '0;
      else        r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
   end

   assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_input_port.sv
`default_nettype none
// ============================================================================
// tb_switch_input_port : directed self-checking bench for switch_input_port
//                        (honours SWITCH_INPUT_PORT_ERR_CNT_EN when defined)
// Revision: 1.0
// ============================================================================
module tb_switch_input_port;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   switch_input_port_if #(.FLIT_W(64), .NUM_VCS(2), .NUM_OUTPORTS(5)) bus ();

`ifdef SWITCH_INPUT_PORT_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   switch_input_port #(
      .FLIT_W       (64),
      .NUM_VCS      (2),
      .BUFFER_DEPTH (4),
      .NUM_OUTPORTS (5)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
`ifdef SWITCH_INPUT_PORT_ERR_CNT_EN
      ,
      .err_count (err_count)
`endif
   );

   logic [63:0] pf [4] = '{64'hF000_0000_0000_0003, 64'hF000_0000_0000_0011,
                           64'hF000_0000_0000_0012, 64'hF000_0000_0000_0013};
   logic [63:0] pg [5] = '{64'hB100_0000_0000_0005, 64'hB100_0000_0000_0021,
                           64'hB100_0000_0000_0022, 64'hB100_0000_0000_0023,
                           64'hB100_0000_0000_00EE};
   logic [63:0] ph [4] = '{64'hC000_0000_0000_0007, 64'hC000_0000_0000_0031,
                           64'hC000_0000_0000_0032, 64'hC000_0000_0000_0033};
   localparam logic [63:0] W0 = 64'hD1D1_0000_0000_000C;
   localparam logic [63:0] S0 = 64'h5000_0000_0000_0009;
   localparam logic [63:0] T0 = 64'h5000_0000_0000_000A;
   localparam logic [63:0] T1 = 64'h5000_0000_0000_0041;
   localparam logic [63:0] U0 = 64'h7700_0000_0000_000B;
   localparam logic [63:0] V0 = 64'hBAD0_0000_0000_0050;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int vc, input logic h, input logic t, input logic [63:0] f);
      bus.in_valid = 1'b1;
      bus.in_vc    = 1'(vc);
      bus.in_head  = h;
      bus.in_tail  = t;
      bus.in_flit  = f;
      @(negedge clk);
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
      bus.in_head  = 1'b0;
      bus.in_tail  = 1'b0;
      bus.in_flit  = '0;
   endtask

   task automatic check_err(input string tag, input int exp);
`ifdef SWITCH_INPUT_PORT_ERR_CNT_EN
      check(tag, 64'(err_count), 64'(exp));
`endif
   endtask

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      idle_in();
      bus.in_vc = '0; bus.rc_done = 1'b0; bus.rc_outport = '0; bus.sa_grant = 1'b0;
      #1;
      check("rst_rc_req", 64'(bus.rc_req), 0);
      check("rst_sa_req", 64'(bus.sa_req), 0);
      check("rst_out_valid", 64'(bus.out_valid), 0);
      check("rst_credit", 64'(bus.credit_valid), 0);
      check("rst_vc_full", 64'(bus.vc_full), 0);
      check_err("rst_err", 0);
      @(negedge clk);
      n_rst = 1'b1;

      // 4-flit packet on VC0
      send(0, 1, 0, pf[0]); send(0, 0, 0, pf[1]); send(0, 0, 0, pf[2]); send(0, 0, 1, pf[3]);
      idle_in();
      #1;
      check("p1_rc_req", 64'(bus.rc_req), 1);
      check("p1_rc_vc", 64'(bus.rc_vc), 0);
      check("p1_rc_flit", bus.rc_flit, pf[0]);
      check("p1_sa_req_idle", 64'(bus.sa_req), 0);
      check("p1_vc_full", 64'(bus.vc_full), 64'h1);
      bus.rc_done = 1'b1; bus.rc_outport = 3'd2;
      @(negedge clk);
      bus.rc_done = 1'b0;
      #1;
      check("p1_rc_req_off", 64'(bus.rc_req), 0);
      check("p1_sa_req", 64'(bus.sa_req), 1);
      check("p1_sa_outport", 64'(bus.sa_outport), 2);
      check("p1_no_out", 64'(bus.out_valid), 0);
      bus.sa_grant = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("p1_out_valid", 64'(bus.out_valid), 1);
         check("p1_out_flit", bus.out_flit, pf[k]);
         if (k > 0) begin
            check("p1_credit", 64'(bus.credit_valid), 1);
            check("p1_credit_vc", 64'(bus.credit_vc), 0);
         end
         @(negedge clk);
      end
      #1;
      check("p1_credit_last", 64'(bus.credit_valid), 1);
      check("p1_idle_sa", 64'(bus.sa_req), 0);
      check("p1_idle_rc", 64'(bus.rc_req), 0);
      bus.sa_grant = 1'b0;
      @(negedge clk);
      #1;
      check("p1_credit_done", 64'(bus.credit_valid), 0);

      // Fill VC1, then overflow write
      send(1, 1, 0, pg[0]); send(1, 0, 0, pg[1]); send(1, 0, 0, pg[2]); send(1, 0, 1, pg[3]);
      #1;
      check("full_vc1", 64'(bus.vc_full), 64'h2);
      send(1, 0, 0, pg[4]);
      idle_in();
      #1;
      check("full_vc1_after", 64'(bus.vc_full), 64'h2);
      check("p2_rc_vc", 64'(bus.rc_vc), 1);
      check("p2_rc_flit", bus.rc_flit, pg[0]);
      check_err("err_overflow", 1);

      // VC0 packet, then both VCs active and alternating
      send(0, 1, 0, ph[0]); send(0, 0, 0, ph[1]); send(0, 0, 0, ph[2]); send(0, 0, 1, ph[3]);
      idle_in();
      #1;
      check("p3_rc_vc0", 64'(bus.rc_vc), 0);
      check("p3_rc_flit0", bus.rc_flit, ph[0]);
      check("p3_vc_full", 64'(bus.vc_full), 64'h3);
      bus.rc_done = 1'b1; bus.rc_outport = 3'd3;
      @(negedge clk);
      bus.rc_outport = 3'd1;
      #1;
      check("p3_rc_vc1", 64'(bus.rc_vc), 1);
      check("p3_rc_flit1", bus.rc_flit, pg[0]);
      check("p3_sa_only0", 64'(bus.sa_outport), 3);
      @(negedge clk);
      bus.rc_done = 1'b0;
      bus.sa_grant = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) begin
            bus.in_valid = 1'b1; bus.in_vc = 1'b1; bus.in_head = 1'b1; bus.in_tail = 1'b1; bus.in_flit = W0;
         end else begin
            idle_in();
         end
         #1;
         check("alt_out_valid", 64'(bus.out_valid), 1);
         check("alt_out_flit", bus.out_flit, (k % 2 == 0) ? pg[k/2] : ph[k/2]);
         check("alt_outport", 64'(bus.sa_outport), (k % 2 == 0) ? 1 : 3);
         if (k > 0) check("alt_credit_vc", 64'(bus.credit_vc), (k % 2 == 1) ? 1 : 0);
         if (k == 1) check("alt_full_both", 64'(bus.vc_full), 64'h3);
         @(negedge clk);
      end
      #1;
      check("alt_credit_last", 64'(bus.credit_vc), 0);
      check("alt_sa_done", 64'(bus.sa_req), 0);
      check("alt_w0_route", bus.rc_flit, W0);
      check_err("err_no_incr", 1);
      bus.sa_grant = 1'b0;

      // Single-flit packet followed by next head
      send(0, 1, 1, S0); send(0, 1, 0, T0); send(0, 0, 1, T1);
      idle_in();
      #1;
      check("sf_rc_vc", 64'(bus.rc_vc), 0);
      check("sf_rc_flit", bus.rc_flit, S0);
      bus.rc_done = 1'b1; bus.rc_outport = 3'd4;
      @(negedge clk);
      bus.rc_done = 1'b0;
      #1;
      check("sf_rc_other", 64'(bus.rc_vc), 1);
      check("sf_sa_outport", 64'(bus.sa_outport), 4);
      bus.sa_grant = 1'b1;
      #1;
      check("sf_out_flit", bus.out_flit, S0);
      @(negedge clk);
      bus.sa_grant = 1'b0;
      #1;
      check("sf_credit", 64'(bus.credit_valid), 1);
      check("sf_sa_idle", 64'(bus.sa_req), 0);
      check("sf_rc_vc_gap", 64'(bus.rc_vc), 1);
      @(negedge clk);
      #1;
      check("sf_next_rc_vc", 64'(bus.rc_vc), 0);
      check("sf_next_rc_flit", bus.rc_flit, T0);
      check("sf_one_credit", 64'(bus.credit_valid), 0);

      // Reset mid-packet with T0/T1 buffered
      bus.rc_done = 1'b1; bus.rc_outport = 3'd1;
      @(negedge clk);
      bus.rc_done = 1'b0; bus.rc_outport = '0;
      #1;
      check("mr_sa_req", 64'(bus.sa_req), 1);
      check("mr_sa_outport", 64'(bus.sa_outport), 1);
      n_rst = 1'b0;
      #1;
      check("mr_sa_req0", 64'(bus.sa_req), 0);
      check("mr_rc_req0", 64'(bus.rc_req), 0);
      check("mr_vc_full0", 64'(bus.vc_full), 0);
      check("mr_outport0", 64'(bus.sa_outport), 0);
      check_err("mr_err0", 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      #1;
      check("mr_no_credit", 64'(bus.credit_valid), 0);
      check("mr_no_sa", 64'(bus.sa_req), 0);
      send(1, 1, 1, U0);
      idle_in();
      @(negedge clk);
      #1;
      check("fr_rc_vc", 64'(bus.rc_vc), 1);
      check("fr_rc_flit", bus.rc_flit, U0);
      bus.rc_done = 1'b1; bus.rc_outport = 3'd2;
      @(negedge clk);
      bus.rc_done = 1'b0;
      #1;
      check("fr_sa_outport", 64'(bus.sa_outport), 2);
      bus.sa_grant = 1'b1;
      #1;
      check("fr_out_flit", bus.out_flit, U0);
      @(negedge clk);
      bus.sa_grant = 1'b0;
      #1;
      check("fr_credit_vc", 64'(bus.credit_vc), 1);
      check("fr_credit", 64'(bus.credit_valid), 1);

      // Non-head flit at the front of an idle VC
      send(0, 0, 0, V0);
      idle_in();
      #1;
      check("nh_rc_req", 64'(bus.rc_req), 0);
      check("nh_no_credit_yet", 64'(bus.credit_valid), 0);
      @(negedge clk);
      #1;
      check("nh_credit", 64'(bus.credit_valid), 1);
      check("nh_credit_vc", 64'(bus.credit_vc), 0);
      check("nh_rc_req2", 64'(bus.rc_req), 0);
      check_err("nh_err", 1);
      @(negedge clk);
      #1;
      check("nh_credit_once", 64'(bus.credit_valid), 0);
      check("nh_sa_req", 64'(bus.sa_req), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
